writeback_unit: RTL and testbench

//   Write-port master for the 32x32 register file (x0 hard-wired zero, write-on-posedge, async read).

---
 rtl/writeback_unit.sv | 144 ++++++++++++++
 tb/tb_writeback_unit.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Register-file write-port master: merges ALU and load results, tracks pending load
// destinations for decode stalls, and forwards the value being written to both read ports.
module writeback_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_value,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] load_rd,
  input  logic [XLEN-1:0]   load_value,
  output logic [ADDR_W-1:0] rf_write_address,
  output logic [XLEN-1:0]   rf_write_value,
  input  logic [ADDR_W-1:0] read_address_1,
  input  logic [ADDR_W-1:0] read_address_2,
  input  logic [XLEN-1:0]   rf_read_value_1,
  input  logic [XLEN-1:0]   rf_read_value_2,
  output logic [XLEN-1:0]   operand_1,
  output logic [XLEN-1:0]   operand_2,
  output logic              busy_1,
  output logic              busy_2
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic                wb_valid_q, wb_valid_d;
  logic                wb_is_load_q, wb_is_load_d;
  logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
  logic [XLEN-1:0]     wb_value_q, wb_value_d;
  logic                skid_valid_q, skid_valid_d;
  logic [ADDR_W-1:0]   skid_rd_q, skid_rd_d;
  logic [XLEN-1:0]     skid_value_q, skid_value_d;
  logic [NumRegs-1:0]  pending_q, pending_d;
  logic                load_fire;

  // Ready only when the skid slot is free, so an accepted load always has somewhere to go.
  assign load_ready = !skid_valid_q && !reset;
  assign load_fire  = load_valid && load_ready;

  always_comb begin
    wb_valid_d   = 1'b0;
    wb_is_load_d = wb_is_load_q;
    wb_addr_d    = wb_addr_q;
    wb_value_d   = wb_value_q;
    skid_valid_d = skid_valid_q;
    skid_rd_d    = skid_rd_q;
    skid_value_d = skid_value_q;

    if (alu_valid) begin
      wb_valid_d   = (alu_rd != '0);
      wb_is_load_d = 1'b0;
      wb_addr_d    = alu_rd;
      wb_value_d   = alu_value;
      if (load_fire) begin
        skid_valid_d = 1'b1;
        skid_rd_d    = load_rd;
        skid_value_d = load_value;
      end
    end else if (skid_valid_q) begin
      wb_valid_d   = (skid_rd_q != '0);
      wb_is_load_d = 1'b1;
      wb_addr_d    = skid_rd_q;
      wb_value_d   = skid_value_q;
      skid_valid_d = 1'b0;
    end else if (load_fire) begin
      wb_valid_d   = (load_rd != '0);
      wb_is_load_d = 1'b1;
      wb_addr_d    = load_rd;
      wb_value_d   = load_value;
    end
  end

  // Clear first so a same-cycle issue to the retiring register wins.
  always_comb begin
    pending_d = pending_q;
    if (wb_valid_q && wb_is_load_q) begin
      pending_d[wb_addr_q] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_valid_q   <= 1'b0;
      wb_is_load_q <= 1'b0;
      wb_addr_q    <= '0;
      wb_value_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_rd_q    <= '0;
      skid_value_q <= '0;
      pending_q    <= '0;
    end else begin
      wb_valid_q   <= wb_valid_d;
      wb_is_load_q <= wb_is_load_d;
      wb_addr_q    <= wb_addr_d;
      wb_value_q   <= wb_value_d;
      skid_valid_q <= skid_valid_d;
      skid_rd_q    <= skid_rd_d;
      skid_value_q <= skid_value_d;
      pending_q    <= pending_d;
    end
  end

  // Gated by reset so the RF sees no write in the cycle reset is first raised.
  always_comb begin
    rf_write_address = (wb_valid_q && !reset) ? wb_addr_q : '0;
    rf_write_value   = reset ? '0 : wb_value_q;
  end

  always_comb begin
    if (read_address_1 == '0) begin
      operand_1 = '0;
    end else if (wb_valid_q && (wb_addr_q == read_address_1)) begin
      operand_1 = wb_value_q;
    end else begin
      operand_1 = rf_read_value_1;
    end
    if (read_address_2 == '0) begin
      operand_2 = '0;
    end else if (wb_valid_q && (wb_addr_q == read_address_2)) begin
      operand_2 = wb_value_q;
    end else begin
      operand_2 = rf_read_value_2;
    end
  end

  // A load being written this cycle is forwarded, so it no longer stalls decode.
  always_comb begin
    busy_1 = !reset && pending_q[read_address_1] &&
             !(wb_valid_q && wb_is_load_q && (wb_addr_q == read_address_1));
    busy_2 = !reset && pending_q[read_address_2] &&
             !(wb_valid_q && wb_is_load_q && (wb_addr_q == read_address_2));
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: expected RF writes go into a queue and a negedge monitor
// pops and compares them; handshake, busy and forwarding values are checked inline.
module tb_writeback_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_value;
  logic        load_valid;
  logic        load_ready;
  logic [4:0]  load_rd;
  logic [31:0] load_value;
  logic [4:0]  rf_write_address;
  logic [31:0] rf_write_value;
  logic [4:0]  read_address_1, read_address_2;
  logic [31:0] rf_read_value_1, rf_read_value_2;
  logic [31:0] operand_1, operand_2;
  logic        busy_1, busy_2;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] value;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;

  writeback_unit #(.XLEN(32), .ADDR_W(5)) dut (
    .clock            (clock),
    .reset            (reset),
    .issue_valid      (issue_valid),
    .issue_rd         (issue_rd),
    .alu_valid        (alu_valid),
    .alu_rd           (alu_rd),
    .alu_value        (alu_value),
    .load_valid       (load_valid),
    .load_ready       (load_ready),
    .load_rd          (load_rd),
    .load_value       (load_value),
    .rf_write_address (rf_write_address),
    .rf_write_value   (rf_write_value),
    .read_address_1   (read_address_1),
    .read_address_2   (read_address_2),
    .rf_read_value_1  (rf_read_value_1),
    .rf_read_value_2  (rf_read_value_2),
    .operand_1        (operand_1),
    .operand_2        (operand_2),
    .busy_1           (busy_1),
    .busy_2           (busy_2)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [4:0] a, input logic [31:0] v);
    wr_t w;
    w.addr  = a;
    w.value = v;
    exp_q.push_back(w);
  endtask

  // Advance to just after the next rising edge with all request strobes dropped.
  task automatic next_cycle();
    @(posedge clock);
    #1;
    issue_valid = 1'b0;
    alu_valid   = 1'b0;
    load_valid  = 1'b0;
  endtask

  task automatic set_alu(input logic [4:0] rd, input logic [31:0] v);
    alu_valid = 1'b1;
    alu_rd    = rd;
    alu_value = v;
  endtask

  task automatic set_load(input logic [4:0] rd, input logic [31:0] v);
    load_valid = 1'b1;
    load_rd    = rd;
    load_value = v;
  endtask

  task automatic set_issue(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd    = rd;
  endtask

  // Monitor: every RF write must match the oldest expected write.
  always @(negedge clock) begin
    if (rf_write_address != 5'd0) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got x%0d=%h, expected no write",
                 rf_write_address, rf_write_value);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        check("wr_addr", {27'd0, rf_write_address}, {27'd0, w.addr});
        check("wr_value", rf_write_value, w.value);
      end
    end
  end

  // Decode legality: no issue or ALU result may target a pending register.
  always @(posedge clock) begin
    if (!reset) begin
      if (issue_valid && issue_rd != 5'd0)
        assert (!dut.pending_q[issue_rd]) else $error("illegal issue to pending x%0d", issue_rd);
      if (alu_valid && alu_rd != 5'd0)
        assert (!dut.pending_q[alu_rd]) else $error("illegal ALU write to pending x%0d", alu_rd);
    end
  end

  initial begin
    reset = 1'b1;
    issue_valid = 1'b0; issue_rd = '0;
    alu_valid = 1'b0; alu_rd = '0; alu_value = '0;
    load_valid = 1'b0; load_rd = '0; load_value = '0;
    read_address_1 = '0; read_address_2 = '0;
    rf_read_value_1 = '0; rf_read_value_2 = '0;

    next_cycle();
    next_cycle();
    read_address_1 = 5'd9;
    #1;
    check("rst_ready", {31'd0, load_ready}, 32'd0);
    check("rst_wr_addr", {27'd0, rf_write_address}, 32'd0);
    check("rst_wr_value", rf_write_value, 32'd0);
    check("rst_busy", {31'd0, busy_1}, 32'd0);
    next_cycle();
    reset = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, load_ready}, 32'd1);

    // 1. ALU only
    next_cycle();
    set_alu(5'd5, 32'hDEADBEEF);
    push(5'd5, 32'hDEADBEEF);
    read_address_1 = 5'd5;
    rf_read_value_1 = 32'h0;
    next_cycle();
    #1;
    check("t1_addr", {27'd0, rf_write_address}, 32'd5);
    check("t1_fwd", operand_1, 32'hDEADBEEF);
    next_cycle();
    #1;
    check("t1_idle", {27'd0, rf_write_address}, 32'd0);

    // 2. Load path with scoreboard stall
    next_cycle();
    set_issue(5'd7);
    read_address_1 = 5'd7;
    rf_read_value_1 = 32'h5555;
    #1;
    check("t2_busy_c0", {31'd0, busy_1}, 32'd0);
    next_cycle();
    #1;
    check("t2_busy_c1", {31'd0, busy_1}, 32'd1);
    next_cycle();
    #1;
    check("t2_busy_c2", {31'd0, busy_1}, 32'd1);
    next_cycle();
    set_load(5'd7, 32'h1234);
    push(5'd7, 32'h1234);
    #1;
    check("t2_ready", {31'd0, load_ready}, 32'd1);
    check("t2_busy_c3", {31'd0, busy_1}, 32'd1);
    next_cycle();
    #1;
    check("t2_busy_c4", {31'd0, busy_1}, 32'd0);
    check("t2_fwd_c4", operand_1, 32'h1234);
    next_cycle();
    #1;
    check("t2_busy_c5", {31'd0, busy_1}, 32'd0);
    check("t2_rf_c5", operand_1, 32'h5555);

    // 3. ALU/load collision
    next_cycle();
    set_alu(5'd3, 32'd1);
    set_load(5'd4, 32'd2);
    push(5'd3, 32'd1);
    push(5'd4, 32'd2);
    #1;
    check("t3_ready_c0", {31'd0, load_ready}, 32'd1);
    next_cycle();
    #1;
    check("t3_ready_c1", {31'd0, load_ready}, 32'd0);
    check("t3_addr_c1", {27'd0, rf_write_address}, 32'd3);
    next_cycle();
    #1;
    check("t3_ready_c2", {31'd0, load_ready}, 32'd1);
    check("t3_addr_c2", {27'd0, rf_write_address}, 32'd4);

    // 4. Back-to-back loads under ALU traffic; writes: A1, A2, A3, L1, L2
    next_cycle();
    set_issue(5'd11);
    next_cycle();
    set_issue(5'd13);
    read_address_2 = 5'd13;
    next_cycle();
    set_alu(5'd10, 32'hA1);
    push(5'd10, 32'hA1);
    set_load(5'd11, 32'hB1);
    #1;
    check("t4_ready_c0", {31'd0, load_ready}, 32'd1);
    check("t4_busy13", {31'd0, busy_2}, 32'd1);
    next_cycle();
    set_alu(5'd12, 32'hA2);
    push(5'd12, 32'hA2);
    set_load(5'd13, 32'hB2);
    #1;
    check("t4_ready_c1", {31'd0, load_ready}, 32'd0);
    next_cycle();
    set_alu(5'd14, 32'hA3);
    push(5'd14, 32'hA3);
    push(5'd11, 32'hB1);
    set_load(5'd13, 32'hB2);
    #1;
    check("t4_ready_c2", {31'd0, load_ready}, 32'd0);
    next_cycle();
    set_load(5'd13, 32'hB2);
    #1;
    check("t4_ready_c3", {31'd0, load_ready}, 32'd0);
    next_cycle();
    set_load(5'd13, 32'hB2);
    push(5'd13, 32'hB2);
    #1;
    check("t4_ready_c4", {31'd0, load_ready}, 32'd1);
    next_cycle();
    next_cycle();
    read_address_1 = 5'd11;
    #1;
    check("t4_busy11_clr", {31'd0, busy_1}, 32'd0);
    check("t4_busy13_clr", {31'd0, busy_2}, 32'd0);

    // 5. x0 writes and issues
    next_cycle();
    set_alu(5'd0, 32'hFFFF);
    set_issue(5'd0);
    read_address_1 = 5'd0;
    read_address_2 = 5'd0;
    rf_read_value_1 = 32'h77;
    rf_read_value_2 = 32'h88;
    next_cycle();
    #1;
    check("t5_addr", {27'd0, rf_write_address}, 32'd0);
    check("t5_busy", {31'd0, busy_1}, 32'd0);
    check("t5_op1", operand_1, 32'd0);
    check("t5_op2", operand_2, 32'd0);

    // 6. Reset with skid full and x9 pending; in-flight results are dropped
    next_cycle();
    set_issue(5'd9);
    read_address_1 = 5'd9;
    next_cycle();
    set_alu(5'd20, 32'hC1);
    set_load(5'd21, 32'hC2);
    #1;
    check("t6_busy9", {31'd0, busy_1}, 32'd1);
    next_cycle();
    reset = 1'b1;
    #1;
    check("t6_ready_rst", {31'd0, load_ready}, 32'd0);
    next_cycle();
    reset = 1'b0;
    #1;
    check("t6_addr", {27'd0, rf_write_address}, 32'd0);
    check("t6_value", rf_write_value, 32'd0);
    check("t6_busy9", {31'd0, busy_1}, 32'd0);
    check("t6_ready", {31'd0, load_ready}, 32'd1);
    next_cycle();
    next_cycle();
    next_cycle();
    #1;
    check("queue_drained", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
